// File: rtl/bus_arbiter_8x1.sv
// Round-robin 8:1 arbiter for the shared result bus, with a
// single-entry output register drained over valid/ready.
module bus_arbiter_8x1 #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC-1:0]       req,
  input  logic [NSRC-1:0]       req_mask,
  input  logic [NSRC*WIDTH-1:0] data_in,
  output logic [NSRC-1:0]       ack,
  output logic                  S2,
  output logic                  S1,
  output logic                  S0,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [2:0]            out_src
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [2:0]       r_src;
  logic [2:0]       r_ptr;

  logic [NSRC-1:0]  w_eff;
  logic [2:0]       w_win;
  logic [2:0]       w_idx;
  logic             w_found;
  logic             w_load;
  logic [2:0]       w_sel;

  assign w_eff = req & req_mask;

  // Scan starts just after the last grant; k=NSRC wraps back to r_ptr.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NSRC; k++) begin
      w_idx = r_ptr + 3'(k);
      if (!w_found && w_eff[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_load = !reset && (|w_eff)
               && (r_state == IDLE || out_ready);

  assign ack   = w_load ? (NSRC'(1) << w_win) : '0;
  assign w_sel = reset ? 3'd0 : (w_load ? w_win : r_src);
  assign {S2, S1, S0} = w_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= 3'd7;
    end else if (w_load) begin
      r_state <= FULL;
      r_data  <= data_in[32'(w_win)*WIDTH +: WIDTH];
      r_src   <= w_win;
      r_ptr   <= w_win;
    end else if (r_state == FULL && out_ready) begin
      r_state <= IDLE;
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule
